// File: rtl/ahb_lite_dmem_decoder.sv
// ---------------------------------------------------------------------------
// ahb_lite_dmem_decoder
//
// AHB-Lite data-memory interconnect between the SCR1 dmem master port and the
// data-side slaves (boot ROM, UART16550). It decodes the address phase,
// remembers which slave owns the following data phase, and muxes the
// response back to the core. Unmapped addresses are answered by an internal
// default slave with a two-cycle AHB ERROR. That slave also keeps a
// saturating error count and the address/direction of the last bad access.
//
// Parameters
//   S0_BASE       HADDR[31:16] match value for slave 0 (ROM)
//   S1_BASE       HADDR[31:16] match value for slave 1 (UART)
//
// Ports
//   clk, rst      HCLK; asynchronous active-high reset
//   m_haddr       master address
//   m_htrans      master transfer type (bit 1 set = NONSEQ/SEQ)
//   m_hwrite      master write flag, used only for error logging
//   m_hrdata      read data to master
//   m_hready      HREADY to master and HREADY input to all slaves
//   m_hresp       response to master (0 OKAY, 1 ERROR)
//   s_hsel        one-hot slave select, bit0 ROM, bit1 UART
//   sN_hrdata     slave read data
//   sN_hreadyout  slave HREADYOUT
//   sN_hresp      slave response
//   err_cnt       saturating count of default-slave ERROR responses
//   err_addr      address of the most recent unmapped transfer
//   err_write     HWRITE of the most recent unmapped transfer
// ---------------------------------------------------------------------------
module ahb_lite_dmem_decoder #(
    parameter logic [15:0] S0_BASE = 16'hFFEF,
    parameter logic [15:0] S1_BASE = 16'hFFDF
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] m_haddr,
    input  logic [1:0]  m_htrans,
    input  logic        m_hwrite,
    output logic [31:0] m_hrdata,
    output logic        m_hready,
    output logic        m_hresp,

    output logic [1:0]  s_hsel,
    input  logic [31:0] s0_hrdata,
    input  logic        s0_hreadyout,
    input  logic        s0_hresp,
    input  logic [31:0] s1_hrdata,
    input  logic        s1_hreadyout,
    input  logic        s1_hresp,

    output logic [7:0]  err_cnt,
    output logic [31:0] err_addr,
    output logic        err_write
);

    typedef enum logic [1:0] {
        DSEL_NONE,
        DSEL_S0,
        DSEL_S1,
        DSEL_DEF
    } dsel_e;

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_ERR1,
        DS_ERR2
    } ds_state_e;

    logic      active;
    logic      hit0;
    logic      hit1;
    logic      def_hit;
    logic      def_take;
    dsel_e     dsel;
    ds_state_e ds_state;
    ds_state_e ds_next;
    logic      def_hready;
    logic      def_hresp;

    // ---------------------------------------------------------------
    // Address-phase decode. IDLE and BUSY never select anything.
    // ---------------------------------------------------------------
    assign active  = m_htrans[1];
    assign hit0    = active && (m_haddr[31:16] == S0_BASE);
    assign hit1    = active && (m_haddr[31:16] == S1_BASE);
    assign def_hit = active && !hit0 && !hit1;
    assign s_hsel  = {hit1, hit0};

    // An unmapped address is only accepted when the bus is not stalled.
    assign def_take = def_hit && m_hready;

    // ---------------------------------------------------------------
    // Data-phase owner. Re-sampled only on a completed data phase, so
    // an address change during a stall is ignored.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dsel <= DSEL_NONE;
        end else if (m_hready) begin
            if (hit0)
                dsel <= DSEL_S0;
            else if (hit1)
                dsel <= DSEL_S1;
            else if (def_hit)
                dsel <= DSEL_DEF;
            else
                dsel <= DSEL_NONE;
        end
    end

    // ---------------------------------------------------------------
    // Default slave: two-cycle ERROR (HREADY low, then high).
    // A new unmapped address sampled in ERR2 restarts at ERR1 without
    // passing through IDLE.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ds_state <= DS_IDLE;
        else
            ds_state <= ds_next;
    end

    always_comb begin
        ds_next = ds_state;
        case (ds_state)
            DS_IDLE: if (def_take) ds_next = DS_ERR1;
            DS_ERR1: ds_next = DS_ERR2;
            DS_ERR2: ds_next = def_take ? DS_ERR1 : DS_IDLE;
            default: ds_next = DS_IDLE;
        endcase
    end

    // Outputs depend on state only, which keeps m_hready free of any
    // path back through the next-state logic.
    always_comb begin
        def_hready = 1'b1;
        def_hresp  = 1'b0;
        case (ds_state)
            DS_ERR1: begin
                def_hready = 1'b0;
                def_hresp  = 1'b1;
            end
            DS_ERR2: begin
                def_hready = 1'b1;
                def_hresp  = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------
    // Response mux
    // ---------------------------------------------------------------
    always_comb begin
        m_hready = 1'b1;
        m_hresp  = 1'b0;
        m_hrdata = 32'h0;
        case (dsel)
            DSEL_S0: begin
                m_hready = s0_hreadyout;
                m_hresp  = s0_hresp;
                m_hrdata = s0_hrdata;
            end
            DSEL_S1: begin
                m_hready = s1_hreadyout;
                m_hresp  = s1_hresp;
                m_hrdata = s1_hrdata;
            end
            DSEL_DEF: begin
                m_hready = def_hready;
                m_hresp  = def_hresp;
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------
    // Error log, updated on every transition into ERR1.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt   <= 8'h00;
            err_addr  <= 32'h0;
            err_write <= 1'b0;
        end else if (def_take) begin
            err_addr  <= m_haddr;
            err_write <= m_hwrite;
            if (err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'h01;
        end
    end

endmodule

// File: tb/tb_ahb_lite_dmem_decoder.sv
// ---------------------------------------------------------------------------
// Testbench for ahb_lite_dmem_decoder.
// The stimulus drives one bus cycle at a time and pushes the response the
// DUT must present in that cycle; a monitor pops on every falling edge and
// compares.
// ---------------------------------------------------------------------------
module tb_ahb_lite_dmem_decoder;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NSEQ = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m_haddr;
    logic [1:0]  m_htrans;
    logic        m_hwrite;
    logic [31:0] m_hrdata;
    logic        m_hready;
    logic        m_hresp;
    logic [1:0]  s_hsel;
    logic [31:0] s0_hrdata, s1_hrdata;
    logic        s0_hreadyout, s1_hreadyout;
    logic        s0_hresp, s1_hresp;
    logic [7:0]  err_cnt;
    logic [31:0] err_addr;
    logic        err_write;

    ahb_lite_dmem_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .m_haddr      (m_haddr),
        .m_htrans     (m_htrans),
        .m_hwrite     (m_hwrite),
        .m_hrdata     (m_hrdata),
        .m_hready     (m_hready),
        .m_hresp      (m_hresp),
        .s_hsel       (s_hsel),
        .s0_hrdata    (s0_hrdata),
        .s0_hreadyout (s0_hreadyout),
        .s0_hresp     (s0_hresp),
        .s1_hrdata    (s1_hrdata),
        .s1_hreadyout (s1_hreadyout),
        .s1_hresp     (s1_hresp),
        .err_cnt      (err_cnt),
        .err_addr     (err_addr),
        .err_write    (err_write)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        resp;
        logic [31:0] rd;
        logic [1:0]  hsel;
        logic        chk_err;
        logic [7:0]  cnt;
        logic [31:0] eaddr;
        logic        ewr;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input string tag,
                       input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s.%s got %h want %h at %0t", tag, name, act, want, $time);
        end
    endtask

    // Monitor: one expected response per bus cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("hready", e.tag, {31'h0, m_hready}, {31'h0, e.rdy});
                chk("hresp",  e.tag, {31'h0, m_hresp},  {31'h0, e.resp});
                chk("hrdata", e.tag, m_hrdata, e.rd);
                chk("hsel",   e.tag, {30'h0, s_hsel},   {30'h0, e.hsel});
                if (e.chk_err) begin
                    chk("err_cnt",   e.tag, {24'h0, err_cnt},   {24'h0, e.cnt});
                    chk("err_addr",  e.tag, err_addr, e.eaddr);
                    chk("err_write", e.tag, {31'h0, err_write}, {31'h0, e.ewr});
                end
            end
        end
    end

    task automatic bus(input logic [31:0] a, input logic [1:0] t, input logic w);
        m_haddr  = a;
        m_htrans = t;
        m_hwrite = w;
    endtask

    task automatic push(input string tag, input logic rdy, input logic resp,
                        input logic [31:0] rd, input logic [1:0] hsel,
                        input logic ce, input logic [7:0] cnt,
                        input logic [31:0] ea, input logic ew);
        exp_t e;
        e.tag = tag; e.rdy = rdy; e.resp = resp; e.rd = rd; e.hsel = hsel;
        e.chk_err = ce; e.cnt = cnt; e.eaddr = ea; e.ewr = ew;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string tag, input logic rdy, input logic resp,
                       input logic [31:0] rd, input logic [1:0] hsel);
        push(tag, rdy, resp, rd, hsel, 1'b0, 8'h0, 32'h0, 1'b0);
    endtask

    task automatic cyc_e(input string tag, input logic rdy, input logic resp,
                         input logic [31:0] rd, input logic [1:0] hsel,
                         input logic [7:0] cnt, input logic [31:0] ea, input logic ew);
        push(tag, rdy, resp, rd, hsel, 1'b1, cnt, ea, ew);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus(32'h0, T_IDLE, 1'b0);
        s0_hrdata = 32'hDEADBEEF; s0_hreadyout = 1'b1; s0_hresp = 1'b0;
        s1_hrdata = 32'h0000_0011; s1_hreadyout = 1'b1; s1_hresp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle bus after reset
        cyc_e("idle0", 1, 0, 32'h0, 2'b00, 8'h00, 32'h0, 1'b0);

        // ROM read
        bus(32'hFFEF_0100, T_NSEQ, 1'b0);
        cyc("rom_a", 1, 0, 32'h0, 2'b01);
        bus(32'h0, T_IDLE, 1'b0);
        cyc("rom_d", 1, 0, 32'hDEADBEEF, 2'b00);
        cyc("idle1", 1, 0, 32'h0, 2'b00);

        // UART read with three wait states; pipelined ROM address waits
        bus(32'hFFDF_0014, T_NSEQ, 1'b0);
        cyc("uart_a", 1, 0, 32'h0, 2'b10);
        bus(32'hFFEF_0200, T_NSEQ, 1'b0);
        s1_hreadyout = 1'b0;
        cyc("uart_w1", 0, 0, 32'h0000_0011, 2'b01);
        bus(32'h0000_0000, T_NSEQ, 1'b1);   // unmapped during stall: ignored
        cyc("uart_w2", 0, 0, 32'h0000_0011, 2'b00);
        bus(32'hFFEF_0200, T_NSEQ, 1'b0);
        cyc("uart_w3", 0, 0, 32'h0000_0011, 2'b01);
        s1_hreadyout = 1'b1;
        s1_hrdata = 32'hA5A5_0014;
        cyc("uart_d", 1, 0, 32'hA5A5_0014, 2'b01);
        bus(32'h0, T_IDLE, 1'b0);
        cyc_e("rom_pipe_d", 1, 0, 32'hDEADBEEF, 2'b00, 8'h00, 32'h0, 1'b0);
        cyc("idle2", 1, 0, 32'h0, 2'b00);

        // Unmapped write
        bus(32'h1234_5678, T_NSEQ, 1'b1);
        cyc("unm_a", 1, 0, 32'h0, 2'b00);
        bus(32'h0, T_IDLE, 1'b0);
        cyc("unm_err1", 0, 1, 32'h0, 2'b00);
        cyc_e("unm_err2", 1, 1, 32'h0, 2'b00, 8'h01, 32'h1234_5678, 1'b1);
        cyc("idle3", 1, 0, 32'h0, 2'b00);

        // Back-to-back errors, second sampled in ERR2
        bus(32'hAAAA_0000, T_NSEQ, 1'b0);
        cyc("b2b_a", 1, 0, 32'h0, 2'b00);
        bus(32'hBBBB_0000, T_NSEQ, 1'b0);
        cyc("b2b_e1", 0, 1, 32'h0, 2'b00);
        cyc("b2b_e2", 1, 1, 32'h0, 2'b00);
        bus(32'h0, T_IDLE, 1'b0);
        cyc_e("b2b_e1b", 0, 1, 32'h0, 2'b00, 8'h03, 32'hBBBB_0000, 1'b0);
        cyc("b2b_e2b", 1, 1, 32'h0, 2'b00);
        cyc("idle4", 1, 0, 32'h0, 2'b00);

        // 300 back-to-back unmapped writes: counter saturates at 0xFF
        bus(32'h0000_1000, T_NSEQ, 1'b1);
        cyc("sat_a", 1, 0, 32'h0, 2'b00);
        for (int i = 0; i < 300; i++) begin
            if (i == 0)
                cyc_e("sat_e1_0", 0, 1, 32'h0, 2'b00, 8'd4, 32'h0000_1000, 1'b1);
            else if (i == 250)
                cyc_e("sat_e1_250", 0, 1, 32'h0, 2'b00, 8'd254, 32'h0000_1000, 1'b1);
            else if (i == 251)
                cyc_e("sat_e1_251", 0, 1, 32'h0, 2'b00, 8'hFF, 32'h0000_1000, 1'b1);
            else
                cyc("sat_e1", 0, 1, 32'h0, 2'b00);
            if (i == 299)
                bus(32'h0, T_IDLE, 1'b0);
            cyc("sat_e2", 1, 1, 32'h0, 2'b00);
        end
        cyc_e("sat_end", 1, 0, 32'h0, 2'b00, 8'hFF, 32'h0000_1000, 1'b1);

        // Slave switching, BUSY bubble
        s0_hrdata = 32'h1111_0000;
        s1_hrdata = 32'h2222_0000;
        bus(32'hFFEF_0000, T_NSEQ, 1'b0);
        cyc("sw_rom_a", 1, 0, 32'h0, 2'b01);
        bus(32'hFFDF_0004, T_NSEQ, 1'b1);
        cyc("sw_uart_a", 1, 0, 32'h1111_0000, 2'b10);
        bus(32'hFFEF_0008, T_NSEQ, 1'b0);
        cyc("sw_rom2_a", 1, 0, 32'h2222_0000, 2'b01);
        bus(32'hFFDF_0008, T_BUSY, 1'b0);
        cyc("sw_busy", 1, 0, 32'h1111_0000, 2'b00);
        bus(32'hFFDF_000C, T_NSEQ, 1'b0);
        cyc("sw_after_busy", 1, 0, 32'h0, 2'b10);
        bus(32'h0, T_IDLE, 1'b0);
        cyc("sw_uart_d", 1, 0, 32'h2222_0000, 2'b00);

        // Slave ERROR pass-through
        bus(32'hFFEF_0010, T_NSEQ, 1'b0);
        cyc("serr_a", 1, 0, 32'h0, 2'b01);
        bus(32'h0, T_IDLE, 1'b0);
        s0_hreadyout = 1'b0; s0_hresp = 1'b1;
        cyc("serr_1", 0, 1, 32'h1111_0000, 2'b00);
        s0_hreadyout = 1'b1;
        cyc("serr_2", 1, 1, 32'h1111_0000, 2'b00);
        s0_hresp = 1'b0;
        cyc("idle5", 1, 0, 32'h0, 2'b00);

        // Reset asserted mid error response
        bus(32'hCCCC_0000, T_NSEQ, 1'b1);
        cyc("rst_a", 1, 0, 32'h0, 2'b00);
        bus(32'h0, T_IDLE, 1'b0);
        cyc("rst_err1", 0, 1, 32'h0, 2'b00);
        rst = 1'b1;
        cyc_e("rst_async", 1, 0, 32'h0, 2'b00, 8'h00, 32'h0, 1'b0);
        bus(32'hFFEF_0000, T_NSEQ, 1'b0);
        cyc("rst_hsel", 1, 0, 32'h0, 2'b01);
        rst = 1'b0;
        bus(32'h0, T_IDLE, 1'b0);
        cyc_e("rst_rel", 1, 0, 32'h0, 2'b00, 8'h00, 32'h0, 1'b0);

        // Drain the scoreboard
        for (int k = 0; k < 10 && exp_q.size() > 0; k++)
            @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain left %0d want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ahb_lite_dmem_decoder.md
# ahb_lite_dmem_decoder

AHB-Lite data-memory interconnect between the SCR1 core's dmem master port and the data-side slaves: boot ROM (0xFFEF_xxxx) and UART16550 (0xFFDF_xxxx). It decodes the address phase, tracks which slave owns the current data phase, and muxes HRDATA/HREADY/HRESP back to the core. An internal default slave returns AHB ERROR for unmapped addresses, and an error counter plus last-error-address register aid bring-up.

## Interface
- S0_BASE, 16'hFFEF: HADDR[31:16] match value for slave 0 (ROM).
- S1_BASE, 16'hFFDF: HADDR[31:16] match value for slave 1 (UART).
- clk  in  1  HCLK. All state changes on the rising edge.
- rst  in  1  Reset, asynchronous, active-high.
- m_haddr  in  32  master address.
- m_htrans  in  2  master transfer type.
- m_hwrite  in  1  master write flag (error logging only; control is broadcast to slaves externally).
- m_hrdata  out  32  read data to master.
- m_hready  out  1  HREADY to master, and HREADY input to all slaves.
- m_hresp  out  1  response to master; 0 = OKAY, 1 = ERROR.
- s_hsel  out  2  one-hot slave select: bit0 = ROM, bit1 = UART.
- s0_hrdata, s1_hrdata  in  32  slave read data.
- s0_hreadyout, s1_hreadyout  in  1  slave HREADYOUT.
- s0_hresp, s1_hresp  in  1  slave response.
- err_cnt  out  8  count of ERROR responses issued by the default slave; saturating.
- err_addr  out  32  address of the most recent unmapped transfer.
- err_write  out  1  HWRITE of the most recent unmapped transfer.

## Operation
- **Active transfer.** A transfer is active when m_htrans[1] = 1 (NONSEQ or SEQ). IDLE and BUSY are never forwarded.
- **Address-phase decode (combinational).**
  - s_hsel[0] = active & (m_haddr[31:16] == S0_BASE).
  - s_hsel[1] = active & (m_haddr[31:16] == S1_BASE).
  - def_hit = active & no match.
- **Data-phase owner register dsel ∈ {NONE, S0, S1, DEF}.**
  - Loaded only when m_hready = 1: S0 or S1 per s_hsel, DEF if def_hit, otherwise NONE.
  - Holds its value while m_hready = 0.
- **Response mux, driven by dsel.**
  - NONE: hready = 1, hresp = 0, hrdata = 0.
  - S0 / S1: pass the selected slave's hrdata, hreadyout and hresp straight through.
  - DEF: outputs come from the default-slave FSM.
- **Default-slave FSM, states DS_IDLE, DS_ERR1, DS_ERR2.**
  - DS_IDLE → DS_ERR1 on a sampled def_hit (m_hready = 1).
  - DS_ERR1: hready = 0, hresp = 1; next state is DS_ERR2 unconditionally.
  - DS_ERR2: hready = 1, hresp = 1. Next state is DS_ERR1 if a new def_hit is sampled this cycle, otherwise DS_IDLE.
  - hrdata = 0 in all default-slave states.
- **Error logging on entry to DS_ERR1.**
  - err_addr ← m_haddr and err_write ← m_hwrite, both sampled with the def_hit.
  - err_cnt ← err_cnt + 1, saturating at 8'hFF; it never wraps.
- **Master behaviour during errors.** The master may drive IDLE or a new address during DS_ERR1. That address is sampled only in DS_ERR2, when hready = 1.
- **Reset (asynchronous).**
  - dsel = NONE, FSM = DS_IDLE, err_cnt = 0, err_addr = 0, err_write = 0.
  - Outputs while in reset: m_hready = 1, m_hresp = 0, m_hrdata = 0, s_hsel follows the decode.
  - A reset asserted mid-transfer abandons the data phase; nothing is replayed.

## Timing
- The decoder adds zero wait states. The decode path and response mux are combinational; the only registers are dsel, the FSM state and the error log.
- The slave data phase starts the cycle after the address phase is sampled. Slave wait states (hreadyout = 0) propagate to m_hready in the same cycle.
- An unmapped access takes exactly two data-phase cycles: ERROR with HREADY low, then ERROR with HREADY high.
- **Back-to-back transfers to different slaves.** The next address phase is sampled on the last data-phase cycle of the current transfer, and dsel switches on that edge.
- **Stalls.** While m_hready = 0, dsel and the decode of the pending address are not re-sampled, even if m_haddr changes.
- **BUSY.** A BUSY or IDLE sampled with m_hready = 1 yields NONE: a one-cycle OKAY with HREADY high.

## Test plan
- **Reset state.** Assert rst mid-cycle → m_hready = 1, m_hresp = 0, m_hrdata = 0 and err_cnt = 0 asynchronously; after release, an IDLE bus gives dsel = NONE.
- **ROM read.** NONSEQ read at 0xFFEF_0100, s0_hrdata = 0xDEADBEEF, s0_hreadyout = 1 → s_hsel = 01 in the address cycle; the next cycle gives m_hrdata = 0xDEADBEEF, m_hready = 1, m_hresp = 0.
- **UART wait states.** NONSEQ read at 0xFFDF_0014 with s1_hreadyout low for 3 cycles → m_hready low for 3 cycles, then high with s1_hrdata. A pipelined ROM address presented meanwhile is not sampled until m_hready = 1.
- **Unmapped write.** NONSEQ write at 0x1234_5678 → s_hsel = 00, then {hready 0, hresp 1} followed by {hready 1, hresp 1}; err_addr = 0x1234_5678, err_write = 1, err_cnt = 1.
- **Back-to-back errors and saturation.**
  - Consecutive unmapped NONSEQs with the next one sampled in DS_ERR2 → the FSM goes ERR1 → ERR2 → ERR1 with no IDLE gap.
  - Repeating 300 times → err_cnt = 0xFF and never wraps.
- **Slave switching and BUSY.** ROM read, UART write and ROM read back-to-back → each response comes from the correct slave with no bubble. A BUSY between them → a one-cycle OKAY with m_hrdata = 0.
